// File: rtl/serial_adder_sequencer.sv
// rtl/serial_adder_sequencer.sv - bit-serial N-bit adder sharing one full-adder cell
// Operands shift out LSB first; the sum assembles MSB-first into a shift register.
module half_adder (
    input  logic i_a,
    input  logic i_b,
    output logic o_s,
    output logic o_c
);
    assign o_s = i_a ^ i_b;
    assign o_c = i_a & i_b;
endmodule

module serial_adder_sequencer #(
    parameter int WIDTH = 8
) (
    input  logic             i_clock,
    input  logic             i_reset_n,
    input  logic             i_start_valid,
    output logic             o_start_ready,
    input  logic [WIDTH-1:0] i_augend,
    input  logic [WIDTH-1:0] i_addend,
    input  logic             i_carry_in,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_carry_out,
    output logic             o_result_valid,
    input  logic             i_result_ready,
    output logic             o_busy
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_aug;
    logic [WIDTH-1:0] r_add;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_sum;
    logic [CW-1:0]    r_cnt;
    logic             r_carry;
    logic             r_cout;

    logic             w_s0;
    logic             w_c0;
    logic             w_sbit;
    logic             w_c1;
    logic             w_cnext;
    logic             w_last;
    logic [WIDTH-1:0] w_acc_next;

    half_adder u_ha0 (.i_a(r_aug[0]), .i_b(r_add[0]), .o_s(w_s0),   .o_c(w_c0));
    half_adder u_ha1 (.i_a(w_s0),     .i_b(r_carry),  .o_s(w_sbit), .o_c(w_c1));

    assign w_cnext = w_c0 | w_c1;
    assign w_last  = (r_cnt == LAST_BIT);

    // Each new sum bit enters at the MSB, so after WIDTH shifts bit 0 sits at the LSB.
    generate
        if (WIDTH == 1) begin : g_acc1
            assign w_acc_next = w_sbit;
        end else begin : g_accn
            assign w_acc_next = {w_sbit, r_acc[WIDTH-1:1]};
        end
    endgenerate

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (i_start_valid) w_next = S_RUN;
            S_RUN:   if (w_last) w_next = S_DONE;
            S_DONE:  if (i_result_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= S_IDLE;
            r_aug   <= '0;
            r_add   <= '0;
            r_acc   <= '0;
            r_sum   <= '0;
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (i_start_valid) begin
                        r_aug   <= i_augend;
                        r_add   <= i_addend;
                        r_carry <= i_carry_in;
                        r_cnt   <= '0;
                    end
                end
                S_RUN: begin
                    r_acc   <= w_acc_next;
                    r_carry <= w_cnext;
                    r_aug   <= r_aug >> 1;
                    r_add   <= r_add >> 1;
                    r_cnt   <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_sum  <= w_acc_next;
                        r_cout <= w_cnext;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_start_ready  = (r_state == S_IDLE) && i_reset_n;
    assign o_result_valid = (r_state == S_DONE);
    assign o_busy         = (r_state != S_IDLE);
    assign o_sum          = r_sum;
    assign o_carry_out    = r_cout;
endmodule

// File: tb/tb_serial_adder_sequencer.sv
// tb/tb_serial_adder_sequencer.sv - self-checking bench for serial_adder_sequencer
module tb_serial_adder_sequencer;
    logic       clk;
    logic       rst_n;

    logic       sv8, rr8, cin8, sr8, cout8, rv8, busy8;
    logic [7:0] aug8, add8, sum8;
    logic       sv1, rr1, cin1, sr1, cout1, rv1, busy1;
    logic [0:0] aug1, add1, sum1;

    int         n_cmp;
    int         n_fail;
    logic       chk_en;
    logic [7:0] exp_sum, held_sum;
    logic       exp_cout, held_cout;

    serial_adder_sequencer #(.WIDTH(8)) u_dut8 (
        .i_clock(clk), .i_reset_n(rst_n), .i_start_valid(sv8), .o_start_ready(sr8),
        .i_augend(aug8), .i_addend(add8), .i_carry_in(cin8), .o_sum(sum8),
        .o_carry_out(cout8), .o_result_valid(rv8), .i_result_ready(rr8), .o_busy(busy8)
    );

    serial_adder_sequencer #(.WIDTH(1)) u_dut1 (
        .i_clock(clk), .i_reset_n(rst_n), .i_start_valid(sv1), .o_start_ready(sr1),
        .i_augend(aug1), .i_addend(add1), .i_carry_in(cin1), .o_sum(sum1),
        .o_carry_out(cout1), .o_result_valid(rv1), .i_result_ready(rr1), .o_busy(busy1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Every cycle: a pending result must be the model's sum, otherwise the last result holds.
    always @(negedge clk) begin
        if (rst_n && chk_en) begin
            if (rv8) begin
                check("done_sum", sum8, exp_sum);
                check("done_cout", cout8, exp_cout);
                check("done_start_ready", sr8, 0);
                check("done_busy", busy8, 1);
            end else begin
                check("hold_sum", sum8, held_sum);
                check("hold_cout", cout8, held_cout);
            end
        end
    end

    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic c,
                       input logic [7:0] lit_sum, input logic lit_cout, input int stall);
        int   lat;
        int   guard;
        logic [8:0] total;
        total    = {1'b0, a} + {1'b0, b} + {8'd0, c};
        exp_sum  = total[7:0];
        exp_cout = total[8];
        guard = 0;
        while (!sr8 && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        check("idle_before_op", sr8, 1);
        sv8 = 1'b1; aug8 = a; add8 = b; cin8 = c;
        @(posedge clk); #1;
        sv8 = 1'b0; aug8 = 8'($urandom); add8 = 8'($urandom); cin8 = 1'($urandom);
        lat = 0;
        while (!rv8 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check("latency", lat, 8);
        check("lit_sum", sum8, lit_sum);
        check("lit_cout", cout8, lit_cout);
        for (int k = 0; k < stall; k++) begin
            sv8 = k[0] ? 1'b0 : 1'b1;
            aug8 = 8'($urandom); add8 = 8'($urandom); cin8 = 1'($urandom);
            @(posedge clk); #1;
            check("stall_valid", rv8, 1);
            check("stall_start_ready", sr8, 0);
            check("stall_sum", sum8, lit_sum);
        end
        sv8 = 1'b0;
        rr8 = 1'b1;
        @(posedge clk); #1;
        rr8 = 1'b0;
        held_sum  = exp_sum;
        held_cout = exp_cout;
        check("post_consume_ready", sr8, 1);
        check("post_consume_busy", busy8, 0);
        check("post_consume_valid", rv8, 0);
    endtask

    task automatic op1(input logic a, input logic b, input logic c);
        int lat;
        logic [1:0] total;
        total = {1'b0, a} + {1'b0, b} + {1'b0, c};
        check("w1_idle", sr1, 1);
        sv1 = 1'b1; aug1 = a; add1 = b; cin1 = c;
        @(posedge clk); #1;
        sv1 = 1'b0; aug1 = ~a; add1 = ~b; cin1 = ~c;
        lat = 0;
        while (!rv1 && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        check("w1_latency", lat, 1);
        check("w1_sum", sum1, total[0]);
        check("w1_cout", cout1, total[1]);
        rr1 = 1'b1;
        @(posedge clk); #1;
        rr1 = 1'b0;
    endtask

    initial begin
        n_cmp = 0; n_fail = 0; chk_en = 1'b0;
        exp_sum = '0; exp_cout = 1'b0; held_sum = '0; held_cout = 1'b0;
        sv8 = 0; rr8 = 0; cin8 = 0; aug8 = '0; add8 = '0;
        sv1 = 0; rr1 = 0; cin1 = 0; aug1 = '0; add1 = '0;
        rst_n = 1'b0;

        repeat (3) begin
            @(negedge clk);
            check("rst_sum", sum8, 8'h00);
            check("rst_cout", cout8, 0);
            check("rst_valid", rv8, 0);
            check("rst_busy", busy8, 0);
            check("rst_start_ready", sr8, 0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        check("rel_start_ready8", sr8, 1);
        check("rel_start_ready1", sr1, 1);
        chk_en = 1'b1;

        op8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 0);
        op8(8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, 0);
        op8(8'hA5, 8'h5A, 1'b0, 8'hFF, 1'b0, 5);

        // Abort mid-RUN: previous result 0xFF must vanish asynchronously.
        sv8 = 1'b1; aug8 = 8'h77; add8 = 8'h11; cin8 = 1'b1;
        @(posedge clk); #1;
        sv8 = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk_en = 1'b0;
        rst_n = 1'b0;
        held_sum = '0; held_cout = 1'b0;
        #1;
        check("abort_sum", sum8, 8'h00);
        check("abort_cout", cout8, 0);
        check("abort_valid", rv8, 0);
        check("abort_busy", busy8, 0);
        check("abort_start_ready", sr8, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk_en = 1'b1;
        op8(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 0);

        for (int v = 0; v < 8; v++) begin
            logic [2:0] vec;
            vec = 3'(v);
            op1(vec[2], vec[1], vec[0]);
        end
        op1(1'b1, 1'b1, 1'b1);
        check("w1_lit_111_sum", sum1, 1);
        check("w1_lit_111_cout", cout1, 1);
        op1(1'b1, 1'b0, 1'b0);
        check("w1_lit_100_sum", sum1, 1);
        check("w1_lit_100_cout", cout1, 0);

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/serial_adder_sequencer.md
# serial_adder_sequencer

Bit-serial N-bit adder controller. It time-shares one full-adder cell, built from two `half_adder` instances and an OR gate, across all operand bits. It shifts one bit per clock, keeps the running carry in a flip-flop, and returns the result through a valid/ready handshake. It is the sequential front end that lets the arithmetic library offer wide addition at single-bit area cost.

## Interface
- `WIDTH`, default 8: operand and sum width in bits. Legal range is WIDTH >= 1.
- `clock`  in  1  single clock; all state changes on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start_valid`  in  1  the operands and `carry_in` are presented.
- `start_ready`  out  1  the block can accept operands (high only in IDLE).
- `augend`  in  WIDTH  first operand; sampled on the accept edge only.
- `addend`  in  WIDTH  second operand; sampled on the accept edge only.
- `carry_in`  in  1  initial carry; sampled on the accept edge only.
- `sum`  out  WIDTH  registered result; holds its value until the next result is produced.
- `carry_out`  out  1  registered final carry; holds its value like `sum`.
- `result_valid`  out  1  `sum` and `carry_out` hold a new, unconsumed result.
- `result_ready`  in  1  the consumer accepts the result.
- `busy`  out  1  high in RUN and DONE.

## Operation
- The FSM has three states: IDLE, RUN and DONE. Reset enters IDLE.
- **IDLE**
  - `start_ready` = 1.
  - When `start_valid` is high, the edge is the accept edge. On it the block loads `augend` and `addend` into the operand shift registers and loads `carry_in` into the carry flip-flop.
  - The accept edge also clears the bit counter and moves the FSM to RUN.
- **RUN**, one bit per cycle, LSB first:
  - half adder 0: inputs are the operand shift-register LSBs; outputs are s0 and c0.
  - half adder 1: inputs are s0 and the carry flip-flop; outputs are the sum bit and c1.
  - On each edge:
    - The sum bit shifts into the MSB of the internal sum shift register.
    - The carry flip-flop takes c0 | c1.
    - The operand registers shift right by one.
    - The counter increments.
  - On the edge that processes bit WIDTH-1:
    - `sum` takes the completed shift-register value.
    - `carry_out` takes c0 | c1.
    - The FSM moves to DONE.
- **DONE**
  - `result_valid` = 1 and `start_ready` = 0.
  - `start_valid` is ignored.
  - An edge with `result_ready` = 1 is the consume edge. It moves the FSM to IDLE.
  - While `result_ready` = 0, the FSM stays in DONE and `sum` and `carry_out` hold.
- **Arithmetic:** {`carry_out`, `sum`} = `augend` + `addend` + `carry_in`, computed modulo 2^(WIDTH+1).
- **Counter:** width is clog2(WIDTH+1). It never wraps within an operation.
- **Reset (asynchronous, any state, including mid-RUN):**
  - The FSM returns to IDLE immediately.
  - All registers clear: `sum` = 0, `carry_out` = 0, `result_valid` = 0, `busy` = 0.
  - `start_ready` = 1 while `reset_n` is high and the FSM is in IDLE; it is 0 while `reset_n` is low.
  - Any in-flight operation is discarded. Nothing is accepted while `reset_n` is low.
- **Output hold:** `sum` and `carry_out` keep the last result through IDLE and RUN until the next DONE entry overwrites them.

## Timing
- The accept edge is E0. RUN occupies the cycles after E0, and edges E1..E(WIDTH) process bits 0..WIDTH-1.
- `result_valid` rises in the cycle after E(WIDTH), which is WIDTH cycles after the accept edge.
- The consume edge returns the FSM to IDLE, and `start_ready` is high in the next cycle. Back-to-back operations can therefore be accepted no more often than every WIDTH+2 cycles.
- There is no bypass: operands are never accepted in the same cycle that a result is consumed.
- WIDTH = 1: exactly one RUN cycle, and `result_valid` rises one cycle after accept.
- Operands may change freely after the accept edge without affecting the operation.
- Outputs are registered only. There is no combinational path from inputs to `sum` or `carry_out`.
- `start_ready` and `result_valid` are decoded from the state register.

## Test plan
- **Reset values:** hold reset for 3 cycles, then release with `start_valid` = 0.
  - During reset: `sum` = 0x00, `carry_out` = 0, `result_valid` = 0, `busy` = 0, `start_ready` = 0.
  - After release: `start_ready` = 1.
- **Basic add with latency check:** WIDTH = 8, `augend` = 0xFF, `addend` = 0x01, `carry_in` = 0.
  - `result_valid` rises exactly 8 cycles after the accept edge, with `sum` = 0x00 and `carry_out` = 1.
- **Full carry-chain propagation:** `augend` = 0xA5, `addend` = 0x5A, `carry_in` = 1.
  - Result: `sum` = 0x00, `carry_out` = 1.
  - Repeat with `carry_in` = 0: `sum` = 0xFF, `carry_out` = 0.
- **Back-pressure:** hold `result_ready` = 0 for 5 cycles in DONE while toggling `start_valid` and the operands.
  - `sum` and `carry_out` stay stable, `result_valid` stays 1, `start_ready` stays 0, and no new operation starts.
  - After release, the FSM is in IDLE one cycle later.
- **Reset mid-RUN:** assert `reset_n` = 0 three cycles after the accept edge.
  - Outputs clear immediately (asynchronously).
  - After release, a fresh 0x12 + 0x34 completes with `sum` = 0x46 and `carry_out` = 0.
- **WIDTH = 1, exhaustive:** all 8 combinations of `augend`, `addend` and `carry_in`.
  - `sum` and `carry_out` match the full-adder truth table, e.g. 1+1+1 gives `sum` = 1, `carry_out` = 1.
  - `result_valid` arrives 1 cycle after each accept.
